// File: rtl/math_alarm_pkg.sv
// Shared types and helpers for the alarm math-challenge sequencer.
// Covers FSM states, operator codes, answer width, and the LFSR / digit-fold helpers.
package math_alarm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GEN    = 3'd1,
    ST_ENTRY  = 3'd2,
    ST_CHECK  = 3'd3,
    ST_WRONG  = 3'd4,
    ST_SOLVED = 3'd5
  } state_t;

  localparam logic [1:0] OP_ADD    = 2'b00;
  localparam logic [1:0] OP_SUB    = 2'b01;
  localparam logic [1:0] OP_MUL    = 2'b10;
  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam int         ANSWER_W  = 7;

  // Galois step for x^16+x^14+x^13+x^11+1, shifting right
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [3:0] digit_fold(input logic [3:0] nib);
    return (nib > DIGIT_MAX) ? (nib - 4'd6) : nib;
  endfunction

endpackage

// File: rtl/key_release_pulse.sv
// Key release detector: tracks a held flag and emits a one-cycle action on release.
// i_clear forces the flag low and suppresses the action.
module key_release_pulse (
  input  logic clock,
  input  logic reset,
  input  logic i_key,
  input  logic i_clear,
  output logic o_pulse
);

  logic r_held;

  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_held <= 1'b0;
    end else begin
      r_held <= i_key;
    end
  end

  assign o_pulse = r_held & ~i_key & ~i_clear;

endmodule

// File: rtl/math_challenge_ctrl.sv
// Alarm silencing sequencer: presents random arithmetic problems while the alarm rings
// and requests alarm_off after NUM_PROBLEMS consecutive correct typed answers.
module math_challenge_ctrl
  import math_alarm_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int          NUM_PROBLEMS   = 3,
  parameter int          PENALTY_CYCLES = 50000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                alarm,
  input  logic [3:0]          digit_sw,
  input  logic                digit_key,
  input  logic                enter_key,
  output logic                alarm_off,
  output logic [3:0]          operand_a,
  output logic [3:0]          operand_b,
  output logic [1:0]          op,
  output logic [ANSWER_W-1:0] entry,
  output logic [1:0]          solved_count,
  output logic                wrong,
  output logic                active
);

  localparam int              PEN_W        = $clog2(PENALTY_CYCLES + 1);
  localparam logic [PEN_W-1:0] PEN_LOAD     = PEN_W'(PENALTY_CYCLES - 1);
  localparam logic [1:0]      SOLVE_TARGET = 2'(NUM_PROBLEMS);

  state_t              r_state, w_next_state;
  logic [15:0]         r_lfsr;
  logic [3:0]          r_operand_a, r_operand_b;
  logic [1:0]          r_op;
  logic [ANSWER_W-1:0] r_entry;
  logic [1:0]          r_solved;
  logic [PEN_W-1:0]    r_penalty;
  logic                r_alarm_off, r_wrong, r_active;
  logic                w_alarm_off, w_wrong, w_active;
  logic                w_digit_pulse, w_enter_pulse, w_lockout, w_digit_act, w_match;
  logic [3:0]          w_na, w_nb;
  logic [1:0]          w_op;
  logic [7:0]          w_prod;
  logic [ANSWER_W-1:0] w_expected;

  assign w_lockout = (r_state == ST_WRONG);

  key_release_pulse u_digit_key (
    .clock   (clock),
    .reset   (reset),
    .i_key   (digit_key),
    .i_clear (w_lockout),
    .o_pulse (w_digit_pulse)
  );

  key_release_pulse u_enter_key (
    .clock   (clock),
    .reset   (reset),
    .i_key   (enter_key),
    .i_clear (w_lockout),
    .o_pulse (w_enter_pulse)
  );

  assign w_na   = digit_fold(r_lfsr[3:0]);
  assign w_nb   = digit_fold(r_lfsr[7:4]);
  assign w_op   = (r_lfsr[9:8] == 2'b11) ? OP_ADD : r_lfsr[9:8];
  assign w_prod = {4'd0, r_operand_a} * {4'd0, r_operand_b};

  always_comb begin
    case (r_op)
      OP_ADD:  w_expected = {3'd0, r_operand_a} + {3'd0, r_operand_b};
      OP_SUB:  w_expected = {3'd0, r_operand_a} - {3'd0, r_operand_b};
      OP_MUL:  w_expected = w_prod[ANSWER_W-1:0];
      default: w_expected = 7'd0;
    endcase
  end

  assign w_match = (r_entry == w_expected);
  // Enter has priority: a digit released on the same cycle is dropped
  assign w_digit_act = w_digit_pulse & ~w_enter_pulse & (digit_sw <= DIGIT_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   w_next_state = alarm ? ST_GEN : ST_IDLE;
      ST_GEN:    w_next_state = ST_ENTRY;
      ST_ENTRY:  w_next_state = w_enter_pulse ? ST_CHECK : ST_ENTRY;
      ST_CHECK: begin
        if (!w_match) begin
          w_next_state = ST_WRONG;
        end else if ((r_solved + 2'd1) == SOLVE_TARGET) begin
          w_next_state = ST_SOLVED;
        end else begin
          w_next_state = ST_GEN;
        end
      end
      ST_WRONG:  w_next_state = (r_penalty == '0) ? ST_GEN : ST_WRONG;
      ST_SOLVED: w_next_state = ST_SOLVED;
      default:   w_next_state = ST_IDLE;
    endcase
    if (!alarm) begin
      w_next_state = ST_IDLE;
    end
  end

  always_comb begin
    w_alarm_off = (w_next_state == ST_SOLVED);
    w_wrong     = (w_next_state == ST_WRONG);
    w_active    = (w_next_state != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_lfsr      <= LFSR_SEED;
      r_operand_a <= 4'd0;
      r_operand_b <= 4'd0;
      r_op        <= 2'b00;
      r_entry     <= 7'd0;
      r_solved    <= 2'd0;
      r_penalty   <= '0;
      r_alarm_off <= 1'b0;
      r_wrong     <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      r_lfsr      <= lfsr_step(r_lfsr);
      r_alarm_off <= w_alarm_off;
      r_wrong     <= w_wrong;
      r_active    <= w_active;
      if (r_state == ST_GEN) begin
        r_op    <= w_op;
        r_entry <= 7'd0;
        // Swap for subtraction so the answer is never negative
        if (w_op == OP_SUB && w_na < w_nb) begin
          r_operand_a <= w_nb;
          r_operand_b <= w_na;
        end else begin
          r_operand_a <= w_na;
          r_operand_b <= w_nb;
        end
      end else if (r_state == ST_ENTRY && w_digit_act) begin
        r_entry <= (r_entry < 7'd10) ? (r_entry * 7'd10 + {3'd0, digit_sw}) : {3'd0, digit_sw};
      end
      if (w_next_state == ST_IDLE) begin
        r_solved <= 2'd0;
      end else if (r_state == ST_CHECK) begin
        r_solved <= w_match ? (r_solved + 2'd1) : 2'd0;
      end
      if (r_state == ST_CHECK && !w_match) begin
        r_penalty <= PEN_LOAD;
      end else if (r_state == ST_WRONG && r_penalty != '0) begin
        r_penalty <= r_penalty - 1'b1;
      end
    end
  end

  assign alarm_off    = r_alarm_off;
  assign operand_a    = r_operand_a;
  assign operand_b    = r_operand_b;
  assign op           = r_op;
  assign entry        = r_entry;
  assign solved_count = r_solved;
  assign wrong        = r_wrong;
  assign active       = r_active;

endmodule

// File: tb/tb_math_challenge_ctrl.sv
// Directed bench for math_challenge_ctrl with a reference LFSR to predict each problem.
module tb_math_challenge_ctrl;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          PEN  = 10;

  logic       clock = 1'b0;
  logic       reset, alarm, digit_key, enter_key;
  logic [3:0] digit_sw;
  logic       alarm_off, wrong, active;
  logic [3:0] operand_a, operand_b;
  logic [1:0] op, solved_count;
  logic [6:0] entry;

  logic [15:0] m_lfsr;
  logic [15:0] snap;
  logic [3:0]  ea, eb;
  logic [1:0]  eop;
  logic [6:0]  eexp;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cnt;
  bit          found;

  math_challenge_ctrl #(
    .LFSR_SEED      (SEED),
    .NUM_PROBLEMS   (3),
    .PENALTY_CYCLES (PEN)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .alarm        (alarm),
    .digit_sw     (digit_sw),
    .digit_key    (digit_key),
    .enter_key    (enter_key),
    .alarm_off    (alarm_off),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .op           (op),
    .entry        (entry),
    .solved_count (solved_count),
    .wrong        (wrong),
    .active       (active)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] nxt(input logic [15:0] l);
    logic [15:0] r;
    r = l >> 1;
    if (l[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  always @(posedge clock) m_lfsr <= reset ? SEED : nxt(m_lfsr);

  task automatic decode(input logic [15:0] l, output logic [3:0] a, output logic [3:0] b,
                        output logic [1:0] o, output logic [6:0] e);
    logic [3:0] t;
    a = (l[3:0] > 4'd9) ? l[3:0] - 4'd6 : l[3:0];
    b = (l[7:4] > 4'd9) ? l[7:4] - 4'd6 : l[7:4];
    o = (l[9:8] == 2'b11) ? 2'b00 : l[9:8];
    if (o == 2'b01 && a < b) begin t = a; a = b; b = t; end
    case (o)
      2'b00:   e = 7'(a) + 7'(b);
      2'b01:   e = 7'(a) - 7'(b);
      default: e = 7'(int'(a) * int'(b));
    endcase
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic press_digit(input logic [3:0] d);
    digit_sw = d; digit_key = 1'b1; step();
    digit_key = 1'b0; step();
  endtask

  task automatic type_answer(input logic [6:0] v);
    if (v >= 7'd10) press_digit(4'(v / 7'd10));
    press_digit(4'(v % 7'd10));
  endtask

  // Leaves the bench one step past CHECK; snapshot is valid if that state is GEN
  task automatic press_enter(output logic [15:0] s);
    enter_key = 1'b1; step();
    enter_key = 1'b0; step();
    step();
    s = m_lfsr;
  endtask

  task automatic check_problem(input string tag);
    decode(snap, ea, eb, eop, eexp);
    check({tag, "_a"}, int'(operand_a), int'(ea));
    check({tag, "_b"}, int'(operand_b), int'(eb));
    check({tag, "_op"}, int'(op), int'(eop));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_off"}, int'(alarm_off), 0);
    check({tag, "_a"}, int'(operand_a), 0);
    check({tag, "_b"}, int'(operand_b), 0);
    check({tag, "_op"}, int'(op), 0);
    check({tag, "_entry"}, int'(entry), 0);
    check({tag, "_solved"}, int'(solved_count), 0);
    check({tag, "_wrong"}, int'(wrong), 0);
    check({tag, "_active"}, int'(active), 0);
  endtask

  initial begin
    reset = 1'b1; alarm = 1'b0; digit_key = 1'b0; enter_key = 1'b0; digit_sw = 4'd0;
    step(); step();
    check_idle_outputs("reset");
    reset = 1'b0;

    // Wait in IDLE until the next GEN would latch 7 mul 8
    found = 1'b0;
    for (int i = 0; i < 70000 && !found; i++) begin
      decode(nxt(m_lfsr), ea, eb, eop, eexp);
      if (ea == 4'd7 && eb == 4'd8 && eop == 2'b10) found = 1'b1;
      else step();
    end
    check("search_7x8", int'(found), 1);
    alarm = 1'b1; step();
    check("rise_active", int'(active), 1);
    snap = m_lfsr; step();
    check("op_valid", int'(op != 2'b11), 1);
    check("a_le9", int'(operand_a <= 4'd9), 1);
    check("mul_a", int'(operand_a), 7);
    check("mul_b", int'(operand_b), 8);
    check("mul_op", int'(op), 2);
    press_digit(4'd5);
    check("entry_5", int'(entry), 5);
    press_digit(4'd6);
    check("entry_56", int'(entry), 56);
    press_enter(snap);
    check("solved_1", int'(solved_count), 1);
    check("gen_active", int'(active), 1);
    step();
    check_problem("p2");

    // Wrong answer on problem 2
    type_answer((eexp == 7'd0) ? 7'd1 : 7'd0);
    press_enter(snap);
    check("wrong_set", int'(wrong), 1);
    check("wrong_count0", int'(solved_count), 0);
    cnt = 1;
    for (int i = 0; i < PEN + 5; i++) begin
      step();
      if (wrong) cnt++;
      else break;
    end
    check("penalty_len", cnt, PEN);
    snap = m_lfsr;
    step();
    check_problem("p3");

    // Three consecutive correct answers
    for (int k = 1; k <= 3; k++) begin
      type_answer(eexp);
      press_enter(snap);
      check("run_solved", int'(solved_count), k);
      check("run_off", int'(alarm_off), (k == 3) ? 1 : 0);
      if (k < 3) begin
        step();
        check_problem("run");
      end
    end
    repeat (5) step();
    check("off_hold", int'(alarm_off), 1);
    alarm = 1'b0; step();
    check("drop_off", int'(alarm_off), 0);
    check("drop_solved", int'(solved_count), 0);
    check("drop_active", int'(active), 0);

    // Entry rules
    alarm = 1'b1; step();
    snap = m_lfsr; step();
    check_problem("p6");
    press_digit(4'd1);
    check("entry_1", int'(entry), 1);
    press_digit(4'd2);
    check("entry_12", int'(entry), 12);
    press_digit(4'd3);
    check("entry_3", int'(entry), 3);
    press_digit(4'd12);
    check("entry_bad_digit", int'(entry), 3);
    digit_sw = 4'd4; digit_key = 1'b1; enter_key = 1'b1; step();
    digit_key = 1'b0; enter_key = 1'b0; step();
    check("entry_same_cycle", int'(entry), 3);
    step();
    if (eexp == 7'd3) begin
      check("same_cycle_ok", int'(solved_count), 1);
      snap = m_lfsr; step();
      decode(snap, ea, eb, eop, eexp);
      type_answer((eexp == 7'd0) ? 7'd1 : 7'd0);
      press_enter(snap);
    end
    check("same_cycle_wrong", int'(wrong), 1);

    // Reset during lockout, then restart from the seed and abort in ENTRY
    repeat (3) step();
    check("still_wrong", int'(wrong), 1);
    reset = 1'b1; step();
    check_idle_outputs("rst_wrong");
    reset = 1'b0; step();
    check("restart_active", int'(active), 1);
    step();
    snap = nxt(SEED);
    check_problem("seed");
    alarm = 1'b0; step();
    check("abort_active", int'(active), 0);
    check("abort_wrong", int'(wrong), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
